// File: rtl/conv3x3_mac_rgb888_pkg.sv
// conv3x3_mac_rgb888_pkg: shared states, widths, channel slices and tap multiplier
package conv_pkg;
  localparam int ACC_W_DEF = 21;
  localparam int SHIFT_DEF = 4;
  localparam int TAPS = 9;
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, SAT = 2'd2} state_e;
  function automatic logic signed [16:0] tap_mul(input logic [7:0] p, input logic [7:0] k);
    return $signed({1'b0, p}) * $signed(k);
  endfunction
endpackage

// File: rtl/conv3x3_mac_rgb888_sat.sv
// conv3x3_sat: round, arithmetic shift and clamp one signed accumulator to 0..255
//   acc in  ACC_W  signed channel accumulator
//   res out 8      clamped channel value
module conv3x3_sat #(
  parameter int ACC_W = 21,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       res
);
  localparam logic [ACC_W-1:0] RND = (SHIFT > 0) ? (ACC_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] r;
  always_comb begin
    sum = acc + RND;
    r = $signed(sum) >>> SHIFT;
    res = r[ACC_W-1] ? 8'h00 : (|r[ACC_W-2:8]) ? 8'hFF : r[7:0];
  end
endmodule

// File: rtl/conv3x3_mac_rgb888.sv
// conv3x3_mac_rgb888: per-channel signed 3x3 convolution of one RGB888 window, one tap per cycle
//   iClk/iRst      clock, async active-low reset
//   iValid         window valid; accepted only when idle
//   iWin0..8       window pixels, row-major, [23:16] R [15:8] G [7:0] B
//   iK0..8         signed kernel weights
//   oBusy          high while a window is in flight (state register decode only)
//   oPixel/oValid  clamped result, held; oValid pulses one cycle on update
module conv3x3_mac_rgb888
  import conv_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic [23:0] iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8,
  input  logic [7:0]  iK0, iK1, iK2, iK3, iK4, iK5, iK6, iK7, iK8,
  output logic        oBusy,
  output logic [23:0] oPixel,
  output logic        oValid
);
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [8:0][23:0]      win_q, win_d;
  logic [8:0][7:0]       k_q, k_d;
  logic [2:0][ACC_W-1:0] acc_q, acc_d;
  logic [23:0]           pixel_q, pixel_d;
  logic                  valid_q, valid_d;
  logic [23:0]           pix;
  logic [7:0]            kw;
  logic [2:0][16:0]      prod;
  logic [2:0][7:0]       sat;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    win_d = win_q;
    k_d = k_q;
    acc_d = acc_q;
    pixel_d = pixel_q;
    valid_d = 1'b0;
    pix = win_q[cnt_q];
    kw = k_q[cnt_q];
    for (int c = 0; c < 3; c++) prod[c] = tap_mul(pix[c*8 +: 8], kw);
    case (state_q)
      IDLE: if (iValid) begin
        win_d = {iWin8, iWin7, iWin6, iWin5, iWin4, iWin3, iWin2, iWin1, iWin0};
        k_d = {iK8, iK7, iK6, iK5, iK4, iK3, iK2, iK1, iK0};
        acc_d = '0;
        cnt_d = '0;
        state_d = MAC;
      end
      MAC: begin
        for (int c = 0; c < 3; c++) acc_d[c] = acc_q[c] + {{(ACC_W-17){prod[c][16]}}, prod[c]};
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(TAPS - 1)) ? SAT : MAC;
      end
      SAT: begin
        pixel_d = {sat[2], sat[1], sat[0]};
        valid_d = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      win_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      k_q <= k_d;
      acc_q <= acc_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
    end
  end
  for (genvar g = 0; g < 3; g++) begin : g_sat
    conv3x3_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_sat (.acc(acc_q[g]), .res(sat[g]));
  end
  assign oBusy = (state_q != IDLE);
  assign oPixel = pixel_q;
  assign oValid = valid_q;
endmodule

// File: tb/tb_conv3x3_mac_rgb888.sv
// tb_conv3x3_mac_rgb888: directed checks of the 3x3 RGB MAC at SHIFT 0, 1 and 4
module tb_conv3x3_mac_rgb888;
  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iValid = 1'b0;
  logic [23:0] win[9];
  logic [7:0]  k[9];
  logic        busy0, busy1, busy4, v0, v1, v4;
  logic [23:0] p0, p1, p4;
  int          errors = 0;
  int          checks = 0;
  int          lat;

  always #5 iClk = ~iClk;

  conv3x3_mac_rgb888 #(.SHIFT(0)) u0 (.iClk(iClk), .iRst(iRst), .iValid(iValid),
    .iWin0(win[0]), .iWin1(win[1]), .iWin2(win[2]), .iWin3(win[3]), .iWin4(win[4]),
    .iWin5(win[5]), .iWin6(win[6]), .iWin7(win[7]), .iWin8(win[8]),
    .iK0(k[0]), .iK1(k[1]), .iK2(k[2]), .iK3(k[3]), .iK4(k[4]), .iK5(k[5]), .iK6(k[6]),
    .iK7(k[7]), .iK8(k[8]), .oBusy(busy0), .oPixel(p0), .oValid(v0));
  conv3x3_mac_rgb888 #(.SHIFT(1)) u1 (.iClk(iClk), .iRst(iRst), .iValid(iValid),
    .iWin0(win[0]), .iWin1(win[1]), .iWin2(win[2]), .iWin3(win[3]), .iWin4(win[4]),
    .iWin5(win[5]), .iWin6(win[6]), .iWin7(win[7]), .iWin8(win[8]),
    .iK0(k[0]), .iK1(k[1]), .iK2(k[2]), .iK3(k[3]), .iK4(k[4]), .iK5(k[5]), .iK6(k[6]),
    .iK7(k[7]), .iK8(k[8]), .oBusy(busy1), .oPixel(p1), .oValid(v1));
  conv3x3_mac_rgb888 #(.SHIFT(4)) u4 (.iClk(iClk), .iRst(iRst), .iValid(iValid),
    .iWin0(win[0]), .iWin1(win[1]), .iWin2(win[2]), .iWin3(win[3]), .iWin4(win[4]),
    .iWin5(win[5]), .iWin6(win[6]), .iWin7(win[7]), .iWin8(win[8]),
    .iK0(k[0]), .iK1(k[1]), .iK2(k[2]), .iK3(k[3]), .iK4(k[4]), .iK5(k[5]), .iK6(k[6]),
    .iK7(k[7]), .iK8(k[8]), .oBusy(busy4), .oPixel(p4), .oValid(v4));

  task automatic fill(input logic [23:0] w, input logic [7:0] kv);
    for (int i = 0; i < 9; i++) begin
      win[i] = w;
      k[i] = kv;
    end
  endtask

  // accept one window, then count edges until oValid (bounded)
  task automatic run(output int n);
    @(negedge iClk);
    iValid = 1'b1;
    @(posedge iClk);
    #1 iValid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge iClk);
      #1 n++;
      if (v0) break;
    end
  endtask

  task automatic test_reset();
    fill(24'hFFFFFF, 8'd1);
    repeat (2) @(posedge iClk);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (p0 !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h want 000000", p0); end
    checks++; if ({v0, v1, v4} !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", {v0, v1, v4}); end
    @(negedge iClk);
    iRst = 1'b1;
  endtask

  task automatic test_identity();
    fill(24'hFFFFFF, 8'd0);
    win[4] = 24'h12AB7F;
    k[4] = 8'd16;
    run(lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL identity_latency: got %0d want 10", lat); end
    checks++; if ({v0, v1, v4} !== 3'b111) begin errors++; $display("FAIL identity_valid: got %b want 111", {v0, v1, v4}); end
    checks++; if ({busy0, busy1, busy4} !== 3'b000) begin errors++; $display("FAIL identity_busy_in_valid: got %b want 000", {busy0, busy1, busy4}); end
    checks++; if (p4 !== 24'h12AB7F) begin errors++; $display("FAIL identity_s4: got %h want 12ab7f", p4); end
    checks++; if (p0 !== 24'hFFFFFF) begin errors++; $display("FAIL identity_s0_clamp: got %h want ffffff", p0); end
    checks++; if (p1 !== 24'h90FFFF) begin errors++; $display("FAIL identity_s1: got %h want 90ffff", p1); end
    @(posedge iClk);
    #1;
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL identity_pulse: got %b want 0", v4); end
    checks++; if (p4 !== 24'h12AB7F) begin errors++; $display("FAIL identity_hold: got %h want 12ab7f", p4); end
  endtask

  task automatic test_box();
    fill(24'h101010, 8'd1);
    run(lat);
    checks++; if (p0 !== 24'h909090) begin errors++; $display("FAIL box16_s0: got %h want 909090", p0); end
    checks++; if (p4 !== 24'h090909) begin errors++; $display("FAIL box16_s4: got %h want 090909", p4); end
    fill(24'h202020, 8'd1);
    run(lat);
    checks++; if (p0 !== 24'hFFFFFF) begin errors++; $display("FAIL box32_s0: got %h want ffffff", p0); end
    checks++; if (p1 !== 24'h909090) begin errors++; $display("FAIL box32_s1: got %h want 909090", p1); end
  endtask

  task automatic test_neg_round();
    fill(24'hFFFFFF, 8'd0);
    win[4] = 24'h404040;
    k[4] = 8'hF8;
    run(lat);
    checks++; if (p0 !== 24'h000000) begin errors++; $display("FAIL neg_clamp: got %h want 000000", p0); end
    fill(24'hFFFFFF, 8'd0);
    win[4] = 24'h030303;
    k[4] = 8'd1;
    run(lat);
    checks++; if (p1 !== 24'h020202) begin errors++; $display("FAIL round_s1: got %h want 020202", p1); end
    checks++; if (p0 !== 24'h030303) begin errors++; $display("FAIL round_s0: got %h want 030303", p0); end
    win[4] = 24'hFF0080;
    run(lat);
    checks++; if (p0 !== 24'hFF0080) begin errors++; $display("FAIL channel_indep: got %h want ff0080", p0); end
  endtask

  // iValid held high; only windows present at edges 0, 11, 22 may be used
  task automatic test_back_to_back();
    @(negedge iClk);
    for (int c = 0; c < 33; c++) begin
      fill(24'h5A5A5A, 8'd7);
      win[4] = {3{8'(c + 1)}};
      if (c % 11 == 0) begin
        for (int i = 0; i < 9; i++) k[i] = 8'd0;
        k[4] = 8'd1;
      end
      iValid = 1'b1;
      @(posedge iClk);
      #1;
      checks++; if (busy0 !== (c % 11 != 10)) begin errors++; $display("FAIL b2b_busy edge %0d: got %b want %b", c, busy0, c % 11 != 10); end
      checks++; if (v0 !== (c % 11 == 10)) begin errors++; $display("FAIL b2b_valid edge %0d: got %b want %b", c, v0, c % 11 == 10); end
      if (c % 11 == 10) begin
        checks++; if (p0 !== {3{8'(c - 9)}}) begin errors++; $display("FAIL b2b_pixel edge %0d: got %h want %h", c, p0, {3{8'(c - 9)}}); end
      end
    end
    iValid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nv;
    fill(24'h101010, 8'd1);
    @(negedge iClk);
    iValid = 1'b1;
    @(posedge iClk);
    #1 iValid = 1'b0;
    repeat (4) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    #1;
    checks++; if ({busy0, busy4} !== 2'b00) begin errors++; $display("FAIL abort_busy: got %b want 00", {busy0, busy4}); end
    checks++; if (p0 !== 24'h0) begin errors++; $display("FAIL abort_pixel: got %h want 000000", p0); end
    @(negedge iClk);
    iRst = 1'b1;
    nv = 0;
    repeat (12) begin
      @(posedge iClk);
      #1 nv += int'(v0);
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", nv); end
    fill(24'hFFFFFF, 8'd0);
    win[4] = 24'h123456;
    k[4] = 8'd1;
    run(lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL post_abort_latency: got %0d want 10", lat); end
    checks++; if (p0 !== 24'h123456) begin errors++; $display("FAIL post_abort_pixel: got %h want 123456", p0); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_box();
    test_neg_round();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/conv3x3_mac_rgb888.md
Name: conv3x3_mac_rgb888

Overview:
- Downstream consumer of the 3x3 RGB888 window generator.
- Accepts one 3x3 window per handshake and convolves each colour channel with a signed 3x3 kernel.
- Uses one tap per cycle through three per-channel multipliers.
- Applies a rounded arithmetic right shift, clamps to 0..255 and emits one RGB888 output pixel.
- Drives the window generator's busy input, which stalls the window while a MAC is in progress.

Parameters:
- SHIFT, 4: arithmetic right shift applied to each channel accumulator; legal range 0..8.
- ACC_W, 21: signed accumulator width per channel. Worst case is 9*255*128 = 293760, plus round, plus sign.

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-low reset.
- iValid  in  1  window valid from the window generator.
- iWin0..iWin8  in  24 each  window pixels, 0 = top-left, row-major; [23:16] R, [15:8] G, [7:0] B.
- iK0..iK8  in  8 each  signed kernel weights, same index order as the window.
- oBusy  out  1  high while a window is being processed; wired to the window generator's busy input.
- oPixel  out  24  result pixel; held until the next result.
- oValid  out  1  one-cycle pulse when oPixel updates.

Behaviour:
- Reset (asynchronous, iRst=0): state=IDLE, tap counter=0, accumulators=0, latched window/kernel=0, oPixel=0, oValid=0, oBusy=0.
- oBusy = (state != IDLE), decoded from the state register only; no combinational path from iValid.
- Accept: on the clock edge where state=IDLE and iValid=1:
  - latch iWin0..8 and iK0..8;
  - clear the three accumulators;
  - go to MAC with cnt=0.
  - iValid while oBusy=1 is ignored and must not disturb the latched data.
- MAC: each edge performs acc_c += zero-extended pix[cnt]_c * signed k[cnt] for c in {R,G,B}.
  - Product is 17-bit signed, sign-extended to ACC_W.
  - cnt increments; after the cnt=8 tap, go to SAT.
  - Exactly 9 MAC edges.
- SAT: per channel, r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT.
  - If r<0 the channel is 0; if r>255 it is 255; otherwise r[7:0].
  - Register oPixel and set oValid=1 for one cycle; go to IDLE.
- Timing: accept edge E0, taps at E1..E9, result at E10.
  - oValid is high during the cycle after E10; oBusy is low in that same cycle.
  - oBusy is high for exactly 10 cycles per window.
  - A new accept may occur in the oValid cycle, giving back-to-back throughput of 1 window per 11 cycles.
- oValid is 0 in every cycle except the one after a SAT edge.
- Reset asserted mid-MAC or mid-SAT aborts the operation immediately. No oValid is produced for the aborted window; oPixel returns to 0.
- Zero-padding is supplied upstream; this block applies no border logic.
- Kernel inputs may change freely while oBusy=1 without effect on the current result.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package conv_pkg:
  - state encodings IDLE/MAC/SAT;
  - ACC_W, SHIFT defaults;
  - channel slice constants R_MSB/R_LSB etc.;
  - a tap-count constant of 9.
- One sub-module, conv3x3_sat: combinational round, shift and clamp of one ACC_W accumulator to 8 bits. Instantiated three times, once per channel.
- FSM, tap counter, latches and multipliers stay in the top module.

Test Plan:
- Identity: K4=16, other weights 0, SHIFT=4, iWin4=0x12AB7F -> oPixel=0x12AB7F, oValid one cycle, 10 edges after accept.
- Box sum: all K=1, SHIFT=0, all pixels 0x101010 -> oPixel=0x909090. Same with pixels 0x202020 -> 0xFFFFFF (288 clamps to 255).
- Negative clamp and rounding:
  - K4=-8, others 0, SHIFT=0, iWin4=0x404040 -> 0x000000.
  - K4=1, SHIFT=1, iWin4=0x030303 -> 0x020202.
  - Per-channel independence: K4=1, SHIFT=0, iWin4=0xFF0080 -> 0xFF0080.
- Handshake: iValid held high continuously with a varying window -> accepts spaced exactly 11 cycles.
  - oBusy high exactly 10 cycles per window.
  - Windows and kernels changed while busy do not affect results.
- Reset at tap 4 of a MAC -> oBusy=0, oPixel=0, no oValid.
  - The next window after release computes correctly with no residue from the aborted accumulation.
- System: connect to the window generator on a 4x3 ramp image. Every emitted window is processed once and the output count equals the window count.
